// File: rtl/pam.sv
// Flat-top PAM generator: an internal sine ROM sampled by an internal
// phase counter, emitted as a registered, optionally shifted pulse train.
module pam #(
   parameter int DIV         = 4,
   parameter int PULSE_WIDTH = 2,
   parameter int SHIFT       = 0
) (
   input  logic        clk,
   input  logic        rst,
   output logic [0:31] pam_out
);

   localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;

   logic [CW-1:0] cnt;
   logic [3:0]    idx;
   logic [7:0]    msg;
   logic          last;
   logic          high;
   logic [31:0]   sample;

   // round(128 + 127*sin(2*pi*k/16))
   always_comb begin
      msg = 8'd128;
      unique case (idx)
         4'd0:  msg = 8'd128;
         4'd1:  msg = 8'd177;
         4'd2:  msg = 8'd218;
         4'd3:  msg = 8'd245;
         4'd4:  msg = 8'd255;
         4'd5:  msg = 8'd245;
         4'd6:  msg = 8'd218;
         4'd7:  msg = 8'd177;
         4'd8:  msg = 8'd128;
         4'd9:  msg = 8'd79;
         4'd10: msg = 8'd38;
         4'd11: msg = 8'd11;
         4'd12: msg = 8'd1;
         4'd13: msg = 8'd11;
         4'd14: msg = 8'd38;
         4'd15: msg = 8'd79;
      endcase
   end

   assign last   = (cnt == CW'(DIV - 1));
   assign high   = (int'(cnt) < PULSE_WIDTH);
   assign sample = {24'd0, msg} << SHIFT;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt     <= '0;
         idx     <= 4'd0;
         pam_out <= 32'd0;
      end else begin
         cnt     <= last ? '0 : cnt + 1'b1;
         idx     <= last ? idx + 4'd1 : idx;
         pam_out <= high ? sample : 32'd0;
      end
   end

endmodule

// File: tb/tb_pam.sv
// Randomized self-checking bench for pam across several parameter sets,
// against a time-based model of the sampled sine.
module tb_pam;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [0:31] o0, o1, o2, o3, o4;

   int passed = 0;
   int total  = 0;
   int t      = 0;

   always #5 clk = ~clk;

   pam u0 (.clk(clk), .rst(rst), .pam_out(o0));
   pam #(.DIV(4), .PULSE_WIDTH(4)) u1 (.clk(clk), .rst(rst), .pam_out(o1));
   pam #(.SHIFT(24)) u2 (.clk(clk), .rst(rst), .pam_out(o2));
   pam #(.DIV(2), .PULSE_WIDTH(1)) u3 (.clk(clk), .rst(rst), .pam_out(o3));
   pam #(.DIV(7), .PULSE_WIDTH(3), .SHIFT(5)) u4 (.clk(clk), .rst(rst), .pam_out(o4));

   function automatic logic [31:0] msg(int k);
      real v;
      v = 128.0 + 127.0 * $sin(2.0 * 3.14159265358979 * (k % 16) / 16.0);
      return 32'($rtoi(v + 0.5));
   endfunction

   // n = edges since reset release; output at edge n reflects time n-1
   function automatic logic [31:0] model(int n, int div, int pw, int sh);
      int tt;
      if (n == 0) return 32'd0;
      tt = n - 1;
      if ((tt % div) >= pw) return 32'd0;
      return msg(tt / div) << sh;
   endfunction

   task automatic step(input logic r);
      rst = r;
      @(posedge clk);
      #1;
      if (r) t = 0;
      else t++;
   endtask

   task automatic test_reset();
      logic [31:0] got [5];
      step(1'b1);
      got = '{o0, o1, o2, o3, o4};
      for (int i = 0; i < 5; i++) begin
         total++;
         if (got[i] !== 32'd0)
            $display("FAIL reset dut%0d got %h want 0", i, got[i]);
         else passed++;
      end
   endtask

   task automatic test_basic();
      logic [31:0] exp [8] = '{128, 128, 0, 0, 177, 177, 0, 0};
      step(1'b1);
      for (int i = 0; i < 8; i++) begin
         step(1'b0);
         total++;
         if (o0 !== exp[i])
            $display("FAIL basic edge%0d got %0d want %0d", i, o0, exp[i]);
         else passed++;
      end
   endtask

   task automatic test_wrap();
      logic [31:0] e;
      step(1'b1);
      for (int i = 0; i < 72; i++) begin
         step(1'b0);
         e = model(t, 4, 2, 0);
         total++;
         if (o0 !== e)
            $display("FAIL wrap edge%0d got %0d want %0d", t, o0, e);
         else passed++;
      end
   endtask

   task automatic test_mid_reset();
      logic [31:0] exp [4] = '{128, 128, 0, 0};
      step(1'b1);
      for (int i = 0; i < 5; i++) step(1'b0);
      step(1'b1);
      total++;
      if (o0 !== 32'd0)
         $display("FAIL midrst got %0d want 0", o0);
      else passed++;
      for (int i = 0; i < 4; i++) begin
         step(1'b0);
         total++;
         if (o0 !== exp[i])
            $display("FAIL midrst edge%0d got %0d want %0d", i, o0, exp[i]);
         else passed++;
      end
   endtask

   task automatic test_staircase();
      logic [31:0] exp [3] = '{128, 177, 218};
      step(1'b1);
      for (int i = 0; i < 12; i++) begin
         step(1'b0);
         total++;
         if (o1 !== exp[i / 4])
            $display("FAIL stair edge%0d got %0d want %0d", i, o1, exp[i / 4]);
         else passed++;
      end
   endtask

   task automatic test_shift();
      step(1'b1);
      step(1'b0);
      total++;
      if (o2 !== 32'h8000_0000)
         $display("FAIL shift first got %h want 80000000", o2);
      else passed++;
      total++;
      if (o2[0] !== 1'b1)
         $display("FAIL shift msb got %b want 1", o2[0]);
      else passed++;
      while (t < 17) step(1'b0);
      total++;
      if (o2 !== 32'hFF00_0000)
         $display("FAIL shift s4 got %h want ff000000", o2);
      else passed++;
   endtask

   task automatic test_div2();
      logic [31:0] exp [8] = '{128, 0, 177, 0, 218, 0, 245, 0};
      step(1'b1);
      for (int i = 0; i < 8; i++) begin
         step(1'b0);
         total++;
         if (o3 !== exp[i])
            $display("FAIL div2 edge%0d got %0d want %0d", i, o3, exp[i]);
         else passed++;
      end
   endtask

   task automatic test_random();
      logic [31:0] got [5];
      logic [31:0] e [5];
      int len;
      logic r;
      for (int it = 0; it < 20; it++) begin
         len = $urandom_range(1, 120);
         for (int k = 0; k < len; k++) begin
            r = ($urandom_range(0, 99) < 3);
            step(r);
            got = '{o0, o1, o2, o3, o4};
            e[0] = r ? 32'd0 : model(t, 4, 2, 0);
            e[1] = r ? 32'd0 : model(t, 4, 4, 0);
            e[2] = r ? 32'd0 : model(t, 4, 2, 24);
            e[3] = r ? 32'd0 : model(t, 2, 1, 0);
            e[4] = r ? 32'd0 : model(t, 7, 3, 5);
            for (int i = 0; i < 5; i++) begin
               total++;
               if (got[i] !== e[i])
                  $display("FAIL rand dut%0d t%0d got %h want %h",
                           i, t, got[i], e[i]);
               else passed++;
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_wrap();
      test_mid_reset();
      test_staircase();
      test_shift();
      test_div2();
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/pam.md
PAM -- requirements
Module: pam

Interface
REQ-001 Parameter DIV, default 4: clock cycles per sampling period; legal range 2..256.
REQ-002 Parameter PULSE_WIDTH, default 2: cycles per period the pulse is high; legal range 1..DIV.
REQ-003 Parameter SHIFT, default 0: left shift applied to each sample before output; legal range 0..24.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 pam_out  output  32  PAM sample stream; declared [0:31], so pam_out[0] is the MSB and pam_out[31] is the LSB.
REQ-007 The block shall have no other ports; message and carrier are both generated internally.

Function
REQ-008 The message source shall be a 16-entry unsigned sine ROM, MSG[k] = round(128 + 127*sin(2*pi*k/16)).
REQ-009 ROM contents, k = 0..15: 128, 177, 218, 245, 255, 245, 218, 177, 128, 79, 38, 11, 1, 11, 38, 79.
REQ-010 Phase counter cnt shall count 0..DIV-1 and wrap to 0; width is ceil(log2(DIV)), minimum 1 bit.
REQ-011 Sample index idx shall be 4 bits and increment mod 16 on each clock where cnt == DIV-1; 15 shall wrap to 0.
REQ-012 Every rising edge with rst=0: pam_out <= (cnt < PULSE_WIDTH) ? zero-extend(MSG[idx]) << SHIFT : 32'd0, using the pre-edge cnt and idx.
REQ-013 The output shall be registered with exactly one cycle of latency from the cnt/idx state; there is no combinational path to pam_out.
REQ-014 Within one period the sample value shall be constant (flat-top PAM): every high cycle of a period carries the same MSG[idx].
REQ-015 If PULSE_WIDTH == DIV, pam_out shall never return to 0 between samples (staircase output).
REQ-016 Shifted values shall always fit in 32 bits (255 << 24 max); no truncation or saturation logic is required.
REQ-017 No handshake exists; the output updates every clock and the consumer samples it freely.

Reset
REQ-018 While rst=1 at a rising edge: cnt <= 0, idx <= 0, pam_out <= 32'd0.
REQ-019 A reset asserted mid-period shall abandon the current period; the first post-reset period restarts at MSG[0].
REQ-020 At simulation start, before the first reset edge, outputs are don't-care; no initial blocks are used for state.
REQ-021 First edge after reset release (defaults): pam_out = 128.

Verification
REQ-022 Defaults, rst high for 1 edge then low for 8 edges -> pam_out per edge: 128, 128, 0, 0, 177, 177, 0, 0.
REQ-023 Defaults, 64 edges after reset -> high-cycle values step through all 16 ROM entries in order, then repeat 128, 177, ... (idx wrap 15->0).
REQ-024 Reset asserted on the 6th post-reset edge (mid-period of sample 1) -> pam_out = 0 on that edge; next edges: 128, 128, 0, 0.
REQ-025 DIV=4, PULSE_WIDTH=4 -> pam_out = 128 x4, 177 x4, 218 x4, with no zero cycles.
REQ-026 SHIFT=24, defaults otherwise -> first edge after reset pam_out = 0x80000000 (pam_out[0]=1, all other bits 0); sample 4 = 0xFF000000.
REQ-027 DIV=2, PULSE_WIDTH=1 -> alternating MSG[k], 0, MSG[k+1], 0, ...; each value held 1 cycle.
